// File: rtl/cpu_pkg.sv
// Shared widths and types for the integer datapath.
// Included by the register file and its storage bank.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/register_bank.sv
// Register storage with one write port and two combinational read taps.
// Entry 0 is never written, so it holds zero after reset.
module register_bank
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;

    assign w_wr_ok = i_we && (i_wr_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_ra_data = r_mem[i_ra_addr];
    assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/register_file_2r1w.sv
// 2-read/1-write register file with registered outputs and a
// read strobe; r0 reads as zero, optional same-cycle write bypass.
module register_file_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              out_valid
);

    logic [DATA_W-1:0] w_bank_a;
    logic [DATA_W-1:0] w_bank_b;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_valid;

    register_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (we),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_ra_addr (rs_addr),
        .i_rb_addr (rt_addr),
        .o_ra_data (w_bank_a),
        .o_rb_data (w_bank_b)
    );

    // Zero check wins over bypass so a write to r0 never leaks out.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        if (addr == ADDR_W'(REG_ZERO)) begin
            return '0;
        end else if (BYPASS && we && (wr_addr == addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    assign w_val_a = read_value(rs_addr, w_bank_a);
    assign w_val_b = read_value(rt_addr, w_bank_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else if (rd_en) begin
            r_a     <= w_val_a;
            r_b     <= w_val_b;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign out_valid = r_valid;

endmodule
